mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Sequences one outstanding memory transaction at a time, returns each response to its owner, and raises per-stage stall signals for the pipeline control path.
- The data port normally wins, so older instructions complete first. A starvation counter guarantees fetch progress.

Parameters:
- XLEN, 32, address/data width.
- STARVE_MAX, 4, consecutive lost arbitrations after which fetch gets forced priority (range 1..15).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_if_req  input  1  fetch request; held until o_if_valid.
- i_if_addr  input  XLEN  fetch address.
- i_if_flush  input  1  pipeline flush; discard any fetch in flight.
- o_if_rdata  output  XLEN  fetched instruction; valid only when o_if_valid.
- o_if_valid  output  1  one-cycle fetch completion pulse.
- o_if_stall  output  1  IF stage must hold.
- i_dm_req  input  1  data request; held until o_dm_valid.
- i_dm_we  input  1  1 = store, 0 = load.
- i_dm_addr  input  XLEN  data address.
- i_dm_wdata  input  XLEN  store data.
- i_dm_be  input  4  byte enables.
- o_dm_rdata  output  XLEN  load data; valid only when o_dm_valid.
- o_dm_valid  output  1  one-cycle data completion pulse (loads and stores).
- o_dm_stall  output  1  MEM stage must hold.
- o_mem_req  output  1  request to memory.
- o_mem_we  output  1  write enable.
- o_mem_addr  output  XLEN  memory address.
- o_mem_wdata  output  XLEN  memory write data.
- o_mem_be  output  4  memory byte enables.
- i_mem_gnt  input  1  memory accepts request this cycle.
- i_mem_rvalid  input  1  response or write-ack pulse.
- i_mem_rdata  input  XLEN  response data.

Behaviour:
- States:
  - IDLE: no transaction owned.
  - HOLD: request presented, not yet granted.
  - WAIT_RSP: granted, awaiting i_mem_rvalid.
- Reset:
  - State IDLE, owner cleared, drop flag 0, starvation counter 0.
  - All outputs 0, and held at 0 until the first rising clock edge after deassertion.
- IDLE arbitration (combinational, same cycle):
  - Candidates are i_dm_req and (i_if_req && !i_if_flush).
  - The data port wins unless the starvation counter equals STARVE_MAX and fetch is a candidate; then fetch wins.
  - The winner drives o_mem_* in the same cycle. Fetch drives we=0, be=4'hF, wdata=0.
  - With gnt=1, go to WAIT_RSP. With gnt=0, go to HOLD.
  - In both cases the owner, address, we, wdata and be are latched.
- HOLD:
  - o_mem_req=1 with the latched fields, held stable until gnt.
  - The request is never withdrawn. On gnt, go to WAIT_RSP.
- WAIT_RSP:
  - o_mem_req=0.
  - On i_mem_rvalid, pulse the owner's valid signal, drive the owner's rdata from i_mem_rdata combinationally, and go to IDLE.
  - Minimum latency: request to valid = 2 cycles (gnt in the issue cycle, rvalid the next).
  - There is one IDLE bubble between back-to-back transactions.
- rdata outputs are 0 whenever the corresponding valid is 0.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on each IDLE arbitration where both ports are candidates and data wins.
  - Clears when a fetch transaction leaves IDLE.
- Flush:
  - i_if_flush while the owner is IF in HOLD or WAIT_RSP sets the drop flag.
  - The transaction completes normally, but o_if_valid stays 0 for its response.
  - The drop flag clears on returning to IDLE.
  - Flush with a data owner has no effect.
- Stalls:
  - o_if_stall = i_if_req && !o_if_valid.
  - o_dm_stall = i_dm_req && !o_dm_valid.
  - Both are combinational, so stall deasserts in the valid cycle.
- i_mem_rvalid outside WAIT_RSP is ignored.
- Asserting reset mid-transaction aborts to IDLE and any late response is ignored.

Test Plan:
- Fetch only:
  - Stimulus: i_if_req=1, addr=0x100; gnt=1 in the same cycle; rvalid next cycle with rdata=0x00500093.
  - Response: o_if_valid pulse with 0x00500093, o_if_stall high for exactly 1 cycle, o_mem_we=0, be=0xF.
- Simultaneous requests:
  - Stimulus: data store (addr 0x200, wdata 0xDEADBEEF, be 0x3) and fetch both requesting.
  - Response: store issued first with o_mem_be=0x3, o_dm_valid on its ack, fetch issued after one IDLE bubble.
- Starvation with STARVE_MAX=4:
  - Stimulus: continuous data requests and a pending fetch.
  - Response: data wins 4 arbitrations, fetch wins the 5th, counter reads 0 afterward.
- Grant backpressure:
  - Stimulus: i_mem_gnt=0 for 3 cycles on a load to 0x300.
  - Response: o_mem_req and all o_mem_* fields stable for 3 cycles, o_dm_stall high throughout, o_dm_valid after gnt and rvalid.
- Flush in flight:
  - Stimulus: i_if_flush in WAIT_RSP for a fetch.
  - Response: rvalid arrives, o_if_valid stays 0, state returns to IDLE, next fetch proceeds normally.
- Reset in WAIT_RSP:
  - Stimulus: i_rst_n low during WAIT_RSP.
  - Response: all outputs 0 immediately, state IDLE, a subsequent i_mem_rvalid produces no valid pulse.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one single-ported unified memory between the instruction-fetch
//   (IF) stage and the load/store (MEM) stage. Only one memory transaction is
//   outstanding at a time. The data port normally wins arbitration so older
//   instructions complete first. A starvation counter forces a fetch through
//   after STARVE_MAX consecutive lost arbitrations. Each response is routed
//   back to the stage that owns it, and per-stage stall signals are produced
//   for the pipeline control path.
//
// Parameters:
//   XLEN        address / data width
//   STARVE_MAX  lost arbitrations before fetch is forced through (1..15)
//
// Ports:
//   i_clk, i_rst_n        clock (rising edge), async active-low reset
//   i_if_req/addr/flush   fetch request, fetch address, pipeline flush
//   o_if_rdata/valid      fetched word and its one-cycle completion pulse
//   o_if_stall            IF stage must hold
//   i_dm_req/we/addr      data request, store select, data address
//   i_dm_wdata/be         store data and byte enables
//   o_dm_rdata/valid      load data and its one-cycle completion pulse
//   o_dm_stall            MEM stage must hold
//   o_mem_req/we/addr     request, write enable and address to memory
//   o_mem_wdata/be        write data and byte enables to memory
//   i_mem_gnt             memory accepts the presented request this cycle
//   i_mem_rvalid/rdata    response (or write acknowledge) and its data
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,

    input  logic            i_if_req,
    input  logic [XLEN-1:0] i_if_addr,
    input  logic            i_if_flush,
    output logic [XLEN-1:0] o_if_rdata,
    output logic            o_if_valid,
    output logic            o_if_stall,

    input  logic            i_dm_req,
    input  logic            i_dm_we,
    input  logic [XLEN-1:0] i_dm_addr,
    input  logic [XLEN-1:0] i_dm_wdata,
    input  logic [3:0]      i_dm_be,
    output logic [XLEN-1:0] o_dm_rdata,
    output logic            o_dm_valid,
    output logic            o_dm_stall,

    output logic            o_mem_req,
    output logic            o_mem_we,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wdata,
    output logic [3:0]      o_mem_be,
    input  logic            i_mem_gnt,
    input  logic            i_mem_rvalid,
    input  logic [XLEN-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HOLD     = 2'd1,
        ST_WAIT_RSP = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_active;
    logic            r_owner_if;
    logic            r_drop;
    logic [3:0]      r_starve_cnt;

    logic            r_we;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [3:0]      r_be;

    logic            w_if_cand;
    logic            w_dm_cand;
    logic            w_any_cand;
    logic            w_fetch_wins;
    logic            w_latch;
    logic            w_rsp;
    logic            w_drop_now;

    logic            w_win_we;
    logic [XLEN-1:0] w_win_addr;
    logic [XLEN-1:0] w_win_wdata;
    logic [3:0]      w_win_be;

    // r_active stays low through reset and for the window between reset
    // release and the first rising edge. Every output is derived either from
    // the FSM (which cannot leave IDLE while r_active is low) or from a term
    // gated by r_active, so the block is silent during that window even if
    // the pipeline is already raising requests.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
        end
    end

    // Arbitration candidates. A fetch that is being flushed in the same cycle
    // is not worth issuing, so it does not compete. Data wins by default;
    // fetch wins when it is alone or when it has lost STARVE_MAX times in a
    // row.
    assign w_if_cand    = r_active && i_if_req && !i_if_flush;
    assign w_dm_cand    = r_active && i_dm_req;
    assign w_any_cand   = w_if_cand || w_dm_cand;
    assign w_fetch_wins = w_if_cand && (!w_dm_cand || (r_starve_cnt == STARVE_LIMIT));

    // Fields presented by the arbitration winner. Fetches are always full-word
    // reads, so they carry a zero write enable, all byte enables and no data.
    always_comb begin
        w_win_we    = i_dm_we;
        w_win_addr  = i_dm_addr;
        w_win_wdata = i_dm_wdata;
        w_win_be    = i_dm_be;
        if (w_fetch_wins) begin
            w_win_we    = 1'b0;
            w_win_addr  = i_if_addr;
            w_win_wdata = '0;
            w_win_be    = 4'hF;
        end
    end

    // Next-state and memory-side outputs. In IDLE the winner drives the
    // memory request combinationally so a same-cycle grant costs nothing. In
    // HOLD the latched copy is presented so the request stays stable even if
    // the pipeline inputs move. In WAIT_RSP the request is dropped and we
    // only watch for the response; a response seen in any other state is
    // ignored because nothing is waiting for it.
    always_comb begin
        w_state_nxt = r_state;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_be    = 4'h0;
        w_latch     = 1'b0;
        w_rsp       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_cand) begin
                    o_mem_req   = 1'b1;
                    o_mem_we    = w_win_we;
                    o_mem_addr  = w_win_addr;
                    o_mem_wdata = w_win_wdata;
                    o_mem_be    = w_win_be;
                    w_latch     = 1'b1;
                    w_state_nxt = i_mem_gnt ? ST_WAIT_RSP : ST_HOLD;
                end
            end
            ST_HOLD: begin
                o_mem_req   = 1'b1;
                o_mem_we    = r_we;
                o_mem_addr  = r_addr;
                o_mem_wdata = r_wdata;
                o_mem_be    = r_be;
                if (i_mem_gnt) begin
                    w_state_nxt = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (i_mem_rvalid) begin
                    w_rsp       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register. An asynchronous reset aborts whatever is in flight, so
    // a response that arrives afterwards finds the FSM in IDLE and is ignored.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture owner and request fields when a transaction leaves IDLE, whether
    // or not it was granted immediately, so HOLD has a stable copy to present.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_owner_if <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= 4'h0;
        end else if (w_latch) begin
            r_owner_if <= w_fetch_wins;
            r_we       <= w_win_we;
            r_addr     <= w_win_addr;
            r_wdata    <= w_win_wdata;
            r_be       <= w_win_be;
        end
    end

    // Drop flag. A flush while a fetch is in flight cannot cancel the memory
    // transaction (the memory has already seen it or is about to), so the
    // transaction runs to completion and only its completion pulse is
    // suppressed. The flag is cleared whenever the FSM returns to IDLE, and a
    // flush has no effect on a data transaction.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_drop <= 1'b0;
        end else if (w_rsp || w_latch) begin
            r_drop <= 1'b0;
        end else if ((r_state != ST_IDLE) && r_owner_if && i_if_flush) begin
            r_drop <= 1'b1;
        end
    end

    // Starvation counter. It counts consecutive arbitrations a competing
    // fetch has lost to the data port and saturates at the limit, where the
    // next contested arbitration goes to fetch. Any fetch leaving IDLE means
    // fetch made progress, so the count restarts.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_starve_cnt <= 4'd0;
        end else if ((r_state == ST_IDLE) && w_any_cand) begin
            if (w_fetch_wins) begin
                r_starve_cnt <= 4'd0;
            end else if (w_if_cand && (r_starve_cnt != STARVE_LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end
    end

    // Response routing. A flush arriving in the very cycle of the response
    // also discards the fetch, matching the intent of the drop flag. Read
    // data is forced to zero whenever the matching valid is low so the
    // pipeline never sees stale memory data.
    assign w_drop_now = r_drop || i_if_flush;
    assign o_if_valid = w_rsp && r_owner_if && !w_drop_now;
    assign o_dm_valid = w_rsp && !r_owner_if;
    assign o_if_rdata = o_if_valid ? i_mem_rdata : '0;
    assign o_dm_rdata = o_dm_valid ? i_mem_rdata : '0;

    // Stalls are purely combinational so they drop in the same cycle as the
    // completion pulse and the stage can advance on that edge.
    assign o_if_stall = r_active && i_if_req && !o_if_valid;
    assign o_dm_stall = r_active && i_dm_req && !o_dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter: directed steps for reset,
// fetch-only, contention, starvation, grant backpressure, flush and reset
// mid-transaction, followed by a randomized run compared against a
// transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int XLEN       = 32;
    localparam int STARVE_MAX = 4;

    logic            i_clk;
    logic            i_rst_n;
    logic            i_if_req;
    logic [XLEN-1:0] i_if_addr;
    logic            i_if_flush;
    logic [XLEN-1:0] o_if_rdata;
    logic            o_if_valid;
    logic            o_if_stall;
    logic            i_dm_req;
    logic            i_dm_we;
    logic [XLEN-1:0] i_dm_addr;
    logic [XLEN-1:0] i_dm_wdata;
    logic [3:0]      i_dm_be;
    logic [XLEN-1:0] o_dm_rdata;
    logic            o_dm_valid;
    logic            o_dm_stall;
    logic            o_mem_req;
    logic            o_mem_we;
    logic [XLEN-1:0] o_mem_addr;
    logic [XLEN-1:0] o_mem_wdata;
    logic [3:0]      o_mem_be;
    logic            i_mem_gnt;
    logic            i_mem_rvalid;
    logic [XLEN-1:0] i_mem_rdata;

    int testCount = 0;
    int failCount = 0;

    // Reference model: the one transaction currently owned by the arbiter,
    // plus how many contested arbitrations fetch has lost in a row.
    bit          mBusy;
    bit          mGranted;
    bit          mFetch;
    bit          mDropped;
    bit          mWe;
    logic [31:0] mAddr;
    logic [31:0] mWdata;
    logic [3:0]  mBe;
    int          mLosses;

    // Randomized requester state.
    logic        rIfReq;
    logic [31:0] rIfAddr;
    logic        rFlush;
    logic        rDmReq;
    logic        rDmWe;
    logic [31:0] rDmAddr;
    logic [31:0] rDmWdata;
    logic [3:0]  rDmBe;
    bit          ifDone;
    bit          dmDone;

    mem_port_arbiter #(
        .XLEN       (XLEN),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_if_req     (i_if_req),
        .i_if_addr    (i_if_addr),
        .i_if_flush   (i_if_flush),
        .o_if_rdata   (o_if_rdata),
        .o_if_valid   (o_if_valid),
        .o_if_stall   (o_if_stall),
        .i_dm_req     (i_dm_req),
        .i_dm_we      (i_dm_we),
        .i_dm_addr    (i_dm_addr),
        .i_dm_wdata   (i_dm_wdata),
        .i_dm_be      (i_dm_be),
        .o_dm_rdata   (o_dm_rdata),
        .o_dm_valid   (o_dm_valid),
        .o_dm_stall   (o_dm_stall),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_be     (o_mem_be),
        .i_mem_gnt    (i_mem_gnt),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata)
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Safety net so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, then wait for
    // the falling edge so outputs are sampled well away from the clock edge.
    task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr,
                                 input logic ifFlush, input logic dmReq,
                                 input logic dmWe, input logic [31:0] dmAddr,
                                 input logic [31:0] dmWdata, input logic [3:0] dmBe,
                                 input logic memGnt, input logic memRvalid,
                                 input logic [31:0] memRdata);
        @(posedge i_clk);
        #1;
        i_if_req     = ifReq;
        i_if_addr    = ifAddr;
        i_if_flush   = ifFlush;
        i_dm_req     = dmReq;
        i_dm_we      = dmWe;
        i_dm_addr    = dmAddr;
        i_dm_wdata   = dmWdata;
        i_dm_be      = dmBe;
        i_mem_gnt    = memGnt;
        i_mem_rvalid = memRvalid;
        i_mem_rdata  = memRdata;
        @(negedge i_clk);
    endtask

    // Reference model step for the current cycle's inputs: works out what the
    // arbiter must present and return, checks it, then advances the model.
    task automatic modelCheck(output bit ifFin, output bit dmFin);
        bit          expReq;
        bit          eWe;
        logic [31:0] eAddr;
        logic [31:0] eWdata;
        logic [3:0]  eBe;
        bit          eIfValid;
        bit          eDmValid;
        logic [31:0] eIfRdata;
        logic [31:0] eDmRdata;
        bit          ifCand;
        bit          fetchWins;
        expReq   = 1'b0;
        eIfValid = 1'b0;
        eDmValid = 1'b0;
        eIfRdata = 32'h0;
        eDmRdata = 32'h0;
        if (!mBusy) begin
            ifCand = i_if_req && !i_if_flush;
            if (i_dm_req || ifCand) begin
                fetchWins = ifCand && (!i_dm_req || (mLosses == STARVE_MAX));
                if (fetchWins) begin
                    mWe     = 1'b0;
                    mAddr   = i_if_addr;
                    mWdata  = 32'h0;
                    mBe     = 4'hF;
                    mLosses = 0;
                end else begin
                    mWe    = i_dm_we;
                    mAddr  = i_dm_addr;
                    mWdata = i_dm_wdata;
                    mBe    = i_dm_be;
                    if (ifCand) begin
                        mLosses = (mLosses < STARVE_MAX) ? mLosses + 1 : STARVE_MAX;
                    end
                end
                mFetch   = fetchWins;
                mBusy    = 1'b1;
                mDropped = 1'b0;
                mGranted = i_mem_gnt;
                expReq   = 1'b1;
            end
        end else if (!mGranted) begin
            expReq = 1'b1;
            if (mFetch && i_if_flush) mDropped = 1'b1;
            if (i_mem_gnt) mGranted = 1'b1;
        end else begin
            if (mFetch && i_if_flush) mDropped = 1'b1;
            if (i_mem_rvalid) begin
                if (mFetch && !mDropped) begin
                    eIfValid = 1'b1;
                    eIfRdata = i_mem_rdata;
                end
                if (!mFetch) begin
                    eDmValid = 1'b1;
                    eDmRdata = i_mem_rdata;
                end
                mBusy = 1'b0;
            end
        end
        eWe    = mWe;
        eAddr  = mAddr;
        eWdata = mWdata;
        eBe    = mBe;
        checkOutput("rnd_mem_req", o_mem_req, expReq);
        if (expReq) begin
            checkOutput("rnd_mem_we", o_mem_we, eWe);
            checkOutput("rnd_mem_addr", o_mem_addr, eAddr);
            checkOutput("rnd_mem_wdata", o_mem_wdata, eWdata);
            checkOutput("rnd_mem_be", o_mem_be, eBe);
        end
        checkOutput("rnd_if_valid", o_if_valid, eIfValid);
        checkOutput("rnd_if_rdata", o_if_rdata, eIfRdata);
        checkOutput("rnd_dm_valid", o_dm_valid, eDmValid);
        checkOutput("rnd_dm_rdata", o_dm_rdata, eDmRdata);
        checkOutput("rnd_if_stall", o_if_stall, i_if_req && !eIfValid);
        checkOutput("rnd_dm_stall", o_dm_stall, i_dm_req && !eDmValid);
        ifFin = eIfValid;
        dmFin = eDmValid;
    endtask

    initial begin
        // Reset with requests already raised: everything must stay quiet.
        i_rst_n      = 1'b0;
        i_if_req     = 1'b0;
        i_if_addr    = 32'h80;
        i_if_flush   = 1'b0;
        i_dm_req     = 1'b1;
        i_dm_we      = 1'b0;
        i_dm_addr    = 32'h40;
        i_dm_wdata   = 32'h0;
        i_dm_be      = 4'hF;
        i_mem_gnt    = 1'b1;
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'h55;
        #12;
        checkOutput("rst_mem_req", o_mem_req, 0);
        checkOutput("rst_mem_addr", o_mem_addr, 0);
        checkOutput("rst_dm_stall", o_dm_stall, 0);
        checkOutput("rst_dm_valid", o_dm_valid, 0);
        checkOutput("rst_if_stall", o_if_stall, 0);
        @(posedge i_clk);
        #2;
        i_rst_n      = 1'b1;
        i_mem_rvalid = 1'b0;
        #2;
        checkOutput("rel_mem_req", o_mem_req, 0);
        checkOutput("rel_dm_stall", o_dm_stall, 0);
        @(posedge i_clk);
        @(negedge i_clk);
        checkOutput("up_mem_req", o_mem_req, 1);
        checkOutput("up_mem_addr", o_mem_addr, 32'h40);
        checkOutput("up_dm_stall", o_dm_stall, 1);
        applyStimulus(0, 32'h0, 0, 1, 0, 32'h40, 32'h0, 4'hF, 0, 1, 32'h11223344);
        checkOutput("up_dm_valid", o_dm_valid, 1);
        checkOutput("up_dm_rdata", o_dm_rdata, 32'h11223344);
        checkOutput("up_dm_stall_rsp", o_dm_stall, 0);
        checkOutput("up_mem_req_rsp", o_mem_req, 0);
        // Stray response in IDLE is ignored.
        applyStimulus(0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 32'hFFFFFFFF);
        checkOutput("stray_dm_valid", o_dm_valid, 0);
        checkOutput("stray_dm_rdata", o_dm_rdata, 0);
        checkOutput("stray_if_valid", o_if_valid, 0);
        checkOutput("stray_if_rdata", o_if_rdata, 0);

        // Fetch only, granted immediately, answered next cycle.
        applyStimulus(1, 32'h100, 0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h0);
        checkOutput("f_mem_req", o_mem_req, 1);
        checkOutput("f_mem_addr", o_mem_addr, 32'h100);
        checkOutput("f_mem_we", o_mem_we, 0);
        checkOutput("f_mem_be", o_mem_be, 4'hF);
        checkOutput("f_mem_wdata", o_mem_wdata, 0);
        checkOutput("f_if_stall_issue", o_if_stall, 1);
        checkOutput("f_if_valid_issue", o_if_valid, 0);
        applyStimulus(1, 32'h100, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 32'h00500093);
        checkOutput("f_if_valid", o_if_valid, 1);
        checkOutput("f_if_rdata", o_if_rdata, 32'h00500093);
        checkOutput("f_if_stall_rsp", o_if_stall, 0);
        checkOutput("f_dm_valid", o_dm_valid, 0);
        applyStimulus(0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0);
        checkOutput("f_if_valid_after", o_if_valid, 0);

        // Simultaneous store and fetch: store first, fetch after the bubble.
        applyStimulus(1, 32'h104, 0, 1, 1, 32'h200, 32'hDEADBEEF, 4'h3, 1, 0, 32'h0);
        checkOutput("s_mem_addr", o_mem_addr, 32'h200);
        checkOutput("s_mem_we", o_mem_we, 1);
        checkOutput("s_mem_be", o_mem_be, 4'h3);
        checkOutput("s_mem_wdata", o_mem_wdata, 32'hDEADBEEF);
        checkOutput("s_if_stall", o_if_stall, 1);
        checkOutput("s_dm_stall", o_dm_stall, 1);
        applyStimulus(1, 32'h104, 0, 1, 1, 32'h200, 32'hDEADBEEF, 4'h3, 0, 1, 32'h0);
        checkOutput("s_dm_valid", o_dm_valid, 1);
        checkOutput("s_dm_stall_ack", o_dm_stall, 0);
        checkOutput("s_if_valid", o_if_valid, 0);
        checkOutput("s_mem_req_wait", o_mem_req, 0);
        applyStimulus(1, 32'h104, 0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h0);
        checkOutput("s_fetch_req", o_mem_req, 1);
        checkOutput("s_fetch_addr", o_mem_addr, 32'h104);
        checkOutput("s_fetch_we", o_mem_we, 0);
        applyStimulus(1, 32'h104, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 32'h00000013);
        checkOutput("s_fetch_valid", o_if_valid, 1);
        checkOutput("s_fetch_rdata", o_if_rdata, 32'h00000013);

        // Starvation: data wins four contested arbitrations, fetch the fifth.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 32'h180, 0, 1, 0, 32'h400 + 32'(4 * k), 32'h0, 4'hF, 1, 0, 32'h0);
            checkOutput("st_dm_addr", o_mem_addr, 32'h400 + 32'(4 * k));
            checkOutput("st_if_stall", o_if_stall, 1);
            applyStimulus(1, 32'h180, 0, 1, 0, 32'h400 + 32'(4 * k), 32'h0, 4'hF, 0, 1, 32'(k));
            checkOutput("st_dm_valid", o_dm_valid, 1);
            checkOutput("st_dm_rdata", o_dm_rdata, 32'(k));
        end
        applyStimulus(1, 32'h180, 0, 1, 0, 32'h410, 32'h0, 4'hF, 1, 0, 32'h0);
        checkOutput("st_fetch_addr", o_mem_addr, 32'h180);
        checkOutput("st_fetch_we", o_mem_we, 0);
        checkOutput("st_fetch_be", o_mem_be, 4'hF);
        checkOutput("st_dm_stall", o_dm_stall, 1);
        applyStimulus(1, 32'h180, 0, 1, 0, 32'h410, 32'h0, 4'hF, 0, 1, 32'h00A00113);
        checkOutput("st_fetch_valid", o_if_valid, 1);
        checkOutput("st_fetch_rdata", o_if_rdata, 32'h00A00113);
        checkOutput("st_dm_valid_none", o_dm_valid, 0);
        checkOutput("st_counter_cleared", 32'(dut.r_starve_cnt), 0);
        applyStimulus(1, 32'h184, 0, 1, 0, 32'h410, 32'h0, 4'hF, 1, 0, 32'h0);
        checkOutput("st_data_wins_again", o_mem_addr, 32'h410);
        applyStimulus(1, 32'h184, 0, 1, 0, 32'h410, 32'h0, 4'hF, 0, 1, 32'h0);
        checkOutput("st_data_valid_again", o_dm_valid, 1);
        applyStimulus(1, 32'h184, 0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h0);
        checkOutput("st_fetch2_addr", o_mem_addr, 32'h184);
        applyStimulus(1, 32'h184, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 32'h1);
        checkOutput("st_fetch2_valid", o_if_valid, 1);
        applyStimulus(0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0);

        // Grant backpressure on a load: request and fields stay stable.
        applyStimulus(0, 32'h0, 0, 1, 0, 32'h300, 32'h0, 4'hF, 0, 0, 32'h0);
        checkOutput("bp_req_0", o_mem_req, 1);
        checkOutput("bp_addr_0", o_mem_addr, 32'h300);
        checkOutput("bp_stall_0", o_dm_stall, 1);
        for (int k = 1; k < 3; k++) begin
            applyStimulus(0, 32'h0, 0, 1, 1, 32'h3FC, 32'h12345678, 4'h1, 0, 0, 32'h0);
            checkOutput("bp_req_hold", o_mem_req, 1);
            checkOutput("bp_addr_hold", o_mem_addr, 32'h300);
            checkOutput("bp_we_hold", o_mem_we, 0);
            checkOutput("bp_be_hold", o_mem_be, 4'hF);
            checkOutput("bp_wdata_hold", o_mem_wdata, 0);
            checkOutput("bp_stall_hold", o_dm_stall, 1);
        end
        applyStimulus(0, 32'h0, 0, 1, 0, 32'h300, 32'h0, 4'hF, 1, 1, 32'hBADBAD00);
        checkOutput("bp_req_gnt", o_mem_req, 1);
        checkOutput("bp_addr_gnt", o_mem_addr, 32'h300);
        checkOutput("bp_valid_at_gnt", o_dm_valid, 0);
        applyStimulus(0, 32'h0, 0, 1, 0, 32'h300, 32'h0, 4'hF, 0, 1, 32'hCAFEF00D);
        checkOutput("bp_valid", o_dm_valid, 1);
        checkOutput("bp_rdata", o_dm_rdata, 32'hCAFEF00D);
        checkOutput("bp_stall_end", o_dm_stall, 0);

        // Flush while a fetch waits for its response.
        applyStimulus(1, 32'h500, 0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h0);
        checkOutput("fl_addr", o_mem_addr, 32'h500);
        applyStimulus(0, 32'h0, 1, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0);
        checkOutput("fl_req_wait", o_mem_req, 0);
        checkOutput("fl_valid_wait", o_if_valid, 0);
        applyStimulus(0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 32'h00000BAD);
        checkOutput("fl_valid_dropped", o_if_valid, 0);
        checkOutput("fl_rdata_dropped", o_if_rdata, 0);
        applyStimulus(1, 32'h600, 0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h0);
        checkOutput("fl_next_req", o_mem_req, 1);
        checkOutput("fl_next_addr", o_mem_addr, 32'h600);
        applyStimulus(1, 32'h600, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 32'h00000777);
        checkOutput("fl_next_valid", o_if_valid, 1);
        checkOutput("fl_next_rdata", o_if_rdata, 32'h00000777);

        // Reset while a load waits for its response.
        applyStimulus(1, 32'h800, 0, 1, 0, 32'h700, 32'h0, 4'hF, 1, 0, 32'h0);
        checkOutput("rw_addr", o_mem_addr, 32'h700);
        @(posedge i_clk);
        #1;
        i_mem_gnt = 1'b0;
        i_rst_n   = 1'b0;
        #1;
        checkOutput("rw_mem_req", o_mem_req, 0);
        checkOutput("rw_if_stall", o_if_stall, 0);
        checkOutput("rw_dm_stall", o_dm_stall, 0);
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'h99;
        #1;
        checkOutput("rw_dm_valid", o_dm_valid, 0);
        checkOutput("rw_dm_rdata", o_dm_rdata, 0);
        @(posedge i_clk);
        #2;
        i_rst_n  = 1'b1;
        i_dm_req = 1'b0;
        i_if_req = 1'b0;
        #1;
        checkOutput("rw_rel_valid", o_dm_valid, 0);
        @(posedge i_clk);
        @(negedge i_clk);
        checkOutput("rw_late_dm_valid", o_dm_valid, 0);
        checkOutput("rw_late_if_valid", o_if_valid, 0);
        checkOutput("rw_late_req", o_mem_req, 0);
        applyStimulus(0, 32'h0, 0, 1, 0, 32'h704, 32'h0, 4'hF, 1, 0, 32'h0);
        checkOutput("rw_idle_req", o_mem_req, 1);
        checkOutput("rw_idle_addr", o_mem_addr, 32'h704);
        applyStimulus(0, 32'h0, 0, 1, 0, 32'h704, 32'h0, 4'hF, 0, 1, 32'h1234);
        checkOutput("rw_idle_valid", o_dm_valid, 1);
        checkOutput("rw_idle_rdata", o_dm_rdata, 32'h1234);

        // Randomized run against the reference model.
        mBusy    = 1'b0;
        mGranted = 1'b0;
        mFetch   = 1'b0;
        mDropped = 1'b0;
        mWe      = 1'b0;
        mAddr    = 32'h0;
        mWdata   = 32'h0;
        mBe      = 4'h0;
        mLosses  = 0;
        rIfReq   = 1'b0;
        rIfAddr  = 32'h0;
        rFlush   = 1'b0;
        rDmReq   = 1'b0;
        rDmWe    = 1'b0;
        rDmAddr  = 32'h0;
        rDmWdata = 32'h0;
        rDmBe    = 4'h0;
        ifDone   = 1'b0;
        dmDone   = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (!rIfReq || ifDone || rFlush) begin
                rIfReq  = ($urandom_range(0, 3) != 0);
                rIfAddr = $urandom & 32'h0000FFFC;
            end
            rFlush = ($urandom_range(0, 11) == 0);
            if (!rDmReq || dmDone) begin
                rDmReq   = ($urandom_range(0, 2) != 0);
                rDmWe    = 1'($urandom_range(0, 1));
                rDmAddr  = $urandom & 32'h0000FFFC;
                rDmWdata = $urandom;
                rDmBe    = 4'($urandom_range(0, 15));
            end
            applyStimulus(rIfReq, rIfAddr, rFlush, rDmReq, rDmWe, rDmAddr, rDmWdata, rDmBe,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            modelCheck(ifDone, dmDone);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
